// File: rtl/cordic_vector_if.sv
// I/Q sample and phase-result bundle for the CORDIC vectoring core.
// Handshake: valid-only streaming. A sample is taken on every rising clk
// edge where valid_i=1; there is no ready/backpressure. valid_o marks the
// cycle in which z_o/inst_freq carry a new result; otherwise they hold.
interface cordic_vector_if;
  logic [11:0] x_i;
  logic [11:0] y_i;
  logic [11:0] z_i;
  logic        valid_i;
  logic [11:0] z_o;
  logic [15:0] inst_freq;
  logic        valid_o;

  modport master (
    output x_i, y_i, z_i, valid_i,
    input  z_o, inst_freq, valid_o
  );

  modport slave (
    input  x_i, y_i, z_i, valid_i,
    output z_o, inst_freq, valid_o
  );
endinterface

// File: rtl/cordic_vector_core.sv
// Fully pipelined vectoring-mode CORDIC: phase of an I/Q sample as a 12-bit
// binary angle plus the wrapped phase step to the previous valid sample.
// Pipeline: input register, pre-rotation, ITER micro-rotations, output.
module cordic_vector_core #(
  parameter int ITER = 11,
  parameter int IW   = 16
) (
  input logic            clk,
  input logic            rst,
  cordic_vector_if.slave bus
);

  // atan(2^-i) in units where 2^15 = pi (16-bit binary angle)
  localparam logic [15:0] ATAN_TAB [0:13] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163,
    16'd81,   16'd41,   16'd20,   16'd10,   16'd5,   16'd3,   16'd1
  };
  localparam logic [IW-1:0] QUARTER = {2'b01, {(IW-2){1'b0}}};

  // input capture
  logic [11:0] in_x, in_y, in_z;
  logic        in_v;

  // pre-rotation combinational result
  logic signed [IW-1:0] sx, sy, px, py;
  logic        [IW-1:0] zb, pz;
  logic                 pnull;

  // stage k holds the result after k micro-rotations (k=0 is pre-rotation)
  logic signed [IW-1:0] xs [0:ITER];
  logic signed [IW-1:0] ys [0:ITER];
  logic        [IW-1:0] zs [0:ITER];
  logic        [ITER:0] vs;
  // (0,0) has no defined angle; the flag freezes z so the result is z_i
  logic        [ITER:0] ns;

  // output stage
  logic [11:0] z_new, d, prev, z_o_r;
  logic [15:0] inst_r;
  logic        vo, first;

  // Valid bits of every stage; reset flushes all in-flight samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_v <= 1'b0;
      vs   <= '0;
    end else begin
      in_v <= bus.valid_i;
      vs   <= {vs[ITER-1:0], in_v};
    end
  end

  // Quadrant fold so the micro-rotations only need to cover +/-90 degrees.
  always_comb begin
    sx    = {{(IW-14){in_x[11]}}, in_x, 2'b00};
    sy    = {{(IW-14){in_y[11]}}, in_y, 2'b00};
    zb    = {in_z, {(IW-12){1'b0}}};
    pnull = (in_x == 12'd0) && (in_y == 12'd0);
    px    = sx;
    py    = sy;
    pz    = zb;
    if (sx[IW-1]) begin
      if (!sy[IW-1]) begin
        px = sy;
        py = -sx;
        pz = zb + QUARTER;
      end else begin
        px = -sy;
        py = sx;
        pz = zb - QUARTER;
      end
    end
  end

  // Datapath registers; contents of bubble stages are don't-care.
  always_ff @(posedge clk) begin
    in_x  <= bus.x_i;
    in_y  <= bus.y_i;
    in_z  <= bus.z_i;
    xs[0] <= px;
    ys[0] <= py;
    zs[0] <= pz;
    ns[0] <= pnull;
    for (int i = 0; i < ITER; i++) begin
      ns[i+1] <= ns[i];
      if (!ys[i][IW-1]) begin
        xs[i+1] <= xs[i] + (ys[i] >>> i);
        ys[i+1] <= ys[i] - (xs[i] >>> i);
        zs[i+1] <= ns[i] ? zs[i] : zs[i] + IW'(ATAN_TAB[i]);
      end else begin
        xs[i+1] <= xs[i] - (ys[i] >>> i);
        ys[i+1] <= ys[i] + (xs[i] >>> i);
        zs[i+1] <= ns[i] ? zs[i] : zs[i] - IW'(ATAN_TAB[i]);
      end
    end
  end

  // Round the IW-bit angle to 12 bits and form the wrapped phase step.
  always_comb begin
    z_new = 12'((zs[ITER] + IW'(8)) >> (IW - 12));
    d     = z_new - prev;
  end

  // Output register: only a valid sample updates results and history.
  always_ff @(posedge clk) begin
    if (rst) begin
      vo     <= 1'b0;
      z_o_r  <= '0;
      inst_r <= '0;
      prev   <= '0;
      first  <= 1'b1;
    end else begin
      vo <= vs[ITER];
      if (vs[ITER]) begin
        z_o_r  <= z_new;
        inst_r <= first ? 16'd0 : {{4{d[11]}}, d};
        prev   <= z_new;
        first  <= 1'b0;
      end
    end
  end

  assign bus.z_o       = z_o_r;
  assign bus.inst_freq = inst_r;
  assign bus.valid_o   = vo;

endmodule

// File: tb/tb_cordic_vector_core.sv
// Bench for cordic_vector_core: directed and random I/Q samples checked
// against an atan2-based phase model with a queue of expected angles.
module tb_cordic_vector_core;
  localparam int ITER = 11;
  localparam int IW   = 16;
  localparam real PI  = 3.14159265358979323846;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_vector_if bus();

  cordic_vector_core #(.ITER(ITER), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int z_tol = 128;   // angle tolerances in 1/64 LSB
  int f_tol = 192;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: ideal phase (1/64 LSB) and expected arrival cycle
  logic [31:0] exp_q[$];
  int          cyc_q[$];

  // wrap a 1/64-LSB angle into [-pi, pi)
  function automatic int wrap64(input int v);
    int m;
    m = v % 262144;
    if (m < 0) m += 262144;
    if (m >= 131072) m -= 262144;
    return m;
  endfunction

  function automatic int ideal64(input int x, input int y, input int z);
    real a;
    if (x == 0 && y == 0) a = 0.0;
    else a = $atan2(real'(y), real'(x));
    return wrap64(z * 64 + int'(a / PI * 131072.0));
  endfunction

  task automatic chk_eq(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs64, input int exp64,
                         input int tol, input bit in_range);
    int err;
    err = wrap64(obs64 - exp64);
    if (err < 0) err = -err;
    tests++;
    assert (((err <= tol) && in_range) === 1'b1) else begin
      fails++;
      $error("FAIL %s observed=%0d/64 expected=%0d/64 tol=%0d/64",
             tag, obs64, exp64, tol);
    end
  endtask

  // monitor / scoreboard
  logic [11:0] held_z = '0;
  logic [15:0] held_f = '0;
  bit          mfirst = 1'b1;
  int          prev64 = 0;

  always @(posedge clk) begin
    int e, c, f;
    #1;
    if (rst) begin
      exp_q.delete();
      cyc_q.delete();
      mfirst = 1'b1;
      held_z = '0;
      held_f = '0;
      chk_eq("rst_valid_o", int'(bus.valid_o), 0);
      chk_eq("rst_z_o", int'(bus.z_o), 0);
      chk_eq("rst_inst_freq", int'(bus.inst_freq), 0);
    end else if (bus.valid_o) begin
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_valid_o", int'(bus.valid_o), 0);
      end else begin
        e = int'($signed(exp_q.pop_front()));
        c = cyc_q.pop_front();
        chk_eq("latency", cyc, c);
        chk_tol("z_o", int'($signed(bus.z_o)) * 64, e, z_tol, 1'b1);
        f = int'($signed(bus.inst_freq));
        if (mfirst) chk_eq("first_inst_freq", f, 0);
        else chk_tol("inst_freq", f * 64, wrap64(e - prev64), f_tol,
                     (f >= -2048) && (f <= 2047));
        prev64 = e;
        mfirst = 1'b0;
        held_z = bus.z_o;
        held_f = bus.inst_freq;
      end
    end else begin
      chk_eq("hold_z_o", int'(bus.z_o), int'(held_z));
      chk_eq("hold_inst_freq", int'(bus.inst_freq), int'(held_f));
    end
  end

  // driver tasks (called at the falling edge)
  task automatic send(input int x, input int y, input int z);
    bus.x_i     = 12'(x);
    bus.y_i     = 12'(y);
    bus.z_i     = 12'(z);
    bus.valid_i = 1'b1;
    exp_q.push_back(32'(ideal64(x, y, z)));
    cyc_q.push_back(cyc + ITER + 3);
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_eq("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic phasor(input bit gaps);
    int k = 0;
    int c = 0;
    real ph;
    while (k < 256) begin
      if (gaps && (c % 3 == 2)) begin
        idle(1);
      end else begin
        ph = 2.0 * PI * real'(k * 64) / 4096.0;
        send(int'(1500.0 * $cos(ph)), int'(1500.0 * $sin(ph)), 0);
        k++;
      end
      c++;
    end
  endtask

  task automatic rand_sample();
    int x, y;
    do begin
      x = int'($urandom_range(0, 4095)) - 2048;
      y = int'($urandom_range(0, 4095)) - 2048;
    end while (x > -256 && x < 256 && y > -256 && y < 256);
    send(x, y, int'($urandom_range(0, 4095)) - 2048);
  endtask

  initial begin
    bus.x_i = '0;
    bus.y_i = '0;
    bus.z_i = '0;
    bus.valid_i = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // isolated directed samples: one quadrant each, then a phase offset
    send(1000, 0, 0);      idle(ITER + 4);
    send(0, 1000, 0);      idle(ITER + 4);
    send(-1000, 0, 0);     idle(ITER + 4);
    send(1000, -1000, 0);  idle(ITER + 4);
    send(1000, 0, 256);    idle(ITER + 4);

    // extreme corners and the undefined-angle origin, back to back
    send(-2048, -2048, 0);
    send(2047, -2048, 0);
    send(-2048, 0, 0);
    send(0, 0, 0);
    send(0, 0, -700);
    send(0, 0, 1234);
    wait_drain();

    // continuous rotating phasor, including the +/-pi crossing
    do_reset();
    phasor(1'b0);
    wait_drain();

    // same phasor with a bubble every third cycle
    do_reset();
    phasor(1'b1);
    wait_drain();

    // random samples with random gaps, then a reset with samples in flight
    do_reset();
    f_tol = 256;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      rand_sample();
    end
    do_reset();
    idle(3);
    send(0, 1000, 0);
    send(1000, 1000, 100);
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      rand_sample();
    end
    wait_drain();
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
